// File: rtl/dispense_pulse_gen.sv
// dispense_pulse_gen: turns request pulses into timed active-low actuator pulses with a queued, saturating backlog
module dispense_pulse_gen #(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8,
    parameter int CNT_W       = 16,
    parameter int PEND_W      = 2
) (
    input  logic              Clk,
    input  logic              nRst,
    input  logic              PulseIn,
    input  logic              OvfClr,
    output logic              ActOut_n,
    output logic              Busy,
    output logic              Done,
    output logic [PEND_W-1:0] Pending,
    output logic              Overflow
);
    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              inc, dec, drop, done_d;
    assign Pending  = pend_q;
    assign Overflow = ovf_q;
    // next-state, hold/gap timing and backlog accounting (a decrement frees room for a same-edge request)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inc     = 1'b0;
        dec     = 1'b0;
        drop    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (PulseIn || pend_q != '0) begin
                state_d = ACTIVE;
                cnt_d   = '0;
                dec     = pend_q != '0;
                inc     = PulseIn && pend_q != '0;
            end
            ACTIVE: if (cnt_q == HOLD_LAST) begin
                state_d = GAP;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else cnt_d = cnt_q + CNT_W'(1);
            GAP: if (cnt_q == GAP_LAST) begin
                state_d = pend_q != '0 ? ACTIVE : IDLE;
                cnt_d   = '0;
                dec     = pend_q != '0;
            end else cnt_d = cnt_q + CNT_W'(1);
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && PulseIn) begin
            inc  = pend_q != PEND_MAX || dec;
            drop = !inc;
        end
        pend_d = pend_q + PEND_W'(inc) - PEND_W'(dec);
        ovf_d  = drop | (ovf_q & ~OvfClr);
    end
    // state and outputs registered together so outputs track the current state
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            ActOut_n <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            ActOut_n <= state_d != ACTIVE;
            Busy     <= state_d != IDLE;
            Done     <= done_d;
        end
    end
endmodule

// File: tb/tb_dispense_pulse_gen.sv
// tb_dispense_pulse_gen: directed and random stimulus checked against an actuation-phase model
module tb_dispense_pulse_gen;
    localparam int H = 4;
    localparam int G = 2;
    localparam int PW = 2;
    localparam int MAXP = 3;
    logic Clk = 1'b0;
    logic nRst = 1'b1;
    logic PulseIn = 1'b0;
    logic OvfClr = 1'b0;
    logic ActOut_n, Busy, Done, Overflow;
    logic [PW-1:0] Pending;
    int n_chk = 0;
    int n_pass = 0;
    int t = -1;
    int pend = 0;
    bit ovf = 1'b0;
    int acts = 0;
    int peak = 0;
    logic prev_act = 1'b1;

    dispense_pulse_gen #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(8), .PEND_W(PW)) dut (
        .Clk(Clk), .nRst(nRst), .PulseIn(PulseIn), .OvfClr(OvfClr),
        .ActOut_n(ActOut_n), .Busy(Busy), .Done(Done), .Pending(Pending), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // t is the position inside one actuation period (0..H+G-1), -1 when idle
    task automatic model_edge(input bit p, input bit c);
        bit acc, dec, drop;
        acc = 0; dec = 0; drop = 0;
        if (t < 0) begin
            if (p || pend > 0) begin
                t = 0;
                if (pend > 0 && !p) pend--;
            end
        end else begin
            dec = (t == H + G - 1) && pend > 0;
            acc = p && (pend < MAXP || dec);
            drop = p && !acc;
            pend = pend + int'(acc) - int'(dec);
            t = (t == H + G - 1) ? (dec ? 0 : -1) : t + 1;
        end
        ovf = drop || (ovf && !c);
    endtask

    task automatic cmp_all();
        chk("act_n", int'(ActOut_n), (t >= 0 && t < H) ? 0 : 1);
        chk("busy", int'(Busy), int'(t >= 0));
        chk("done", int'(Done), int'(t == H));
        chk("pending", int'(Pending), pend);
        chk("overflow", int'(Overflow), int'(ovf));
    endtask

    task automatic step(input bit p, input bit c);
        PulseIn = p;
        OvfClr = c;
        @(posedge Clk);
        model_edge(p, c);
        #1;
        if (prev_act && !ActOut_n) acts++;
        prev_act = ActOut_n;
        if (int'(Pending) > peak) peak = int'(Pending);
        cmp_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0);
    endtask

    task automatic seg();
        acts = 0;
        peak = 0;
    endtask

    task automatic async_rst();
        #3 nRst = 1'b0;
        #1;
        t = -1; pend = 0; ovf = 0;
        cmp_all();
        @(negedge Clk) nRst = 1'b1;
        prev_act = 1'b1;
    endtask

    initial begin
        #2 nRst = 1'b0;
        #10;
        cmp_all();
        @(negedge Clk) nRst = 1'b1;
        // single actuation
        seg();
        step(1, 0);
        chk("t1_latency", int'(ActOut_n), 0);
        idle(10);
        chk("t1_acts", acts, 1);
        // three queued during ACTIVE
        seg();
        repeat (4) step(1, 0);
        chk("t2_pend", int'(Pending), 3);
        idle(40);
        chk("t2_acts", acts, 4);
        chk("t2_ovf", int'(Overflow), 0);
        // saturation and overflow clear
        seg();
        repeat (6) step(1, 0);
        chk("t3_pend", int'(Pending), 3);
        chk("t3_ovf", int'(Overflow), 1);
        idle(40);
        chk("t3_acts", acts, 4);
        step(0, 1);
        chk("t3_clr", int'(Overflow), 0);
        // request on the GAP->ACTIVE edge with a full backlog
        seg();
        repeat (4) step(1, 0);
        idle(2);
        step(1, 0);
        chk("t4_pend", int'(Pending), 3);
        chk("t4_ovf", int'(Overflow), 0);
        idle(60);
        chk("t4_acts", acts, 5);
        // async reset mid-ACTIVE
        repeat (3) step(1, 0);
        async_rst();
        chk("t5_act_n", int'(ActOut_n), 1);
        chk("t5_busy", int'(Busy), 0);
        seg();
        idle(20);
        chk("t5_acts", acts, 0);
        // held request
        seg();
        repeat (3) step(1, 0);
        idle(40);
        chk("t6_acts", acts, 3);
        chk("t6_peak", peak, 2);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int dens;
            dens = ((i / 100) % 4) * 15 + 5;
            step($urandom_range(99) < dens, $urandom_range(19) == 0);
            if ($urandom_range(299) == 0) async_rst();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
